vga_timing_receiver: RTL and testbench

- Receive-side counterpart of the VGA driver: accepts a VGA-style pixel stream (RGB, hsync, vsync, blank) and recovers pixel coordinates, a pixel strobe, and a frame-start pulse.
- Qualifies timing against expected active geometry and reports lock status and an error count.
- Sits at the video input of the SoC, ahead of any capture/framebuffer writer, or in loopback on the driver outputs for self-test.

---
 rtl/vga_timing_receiver_if.sv | 33 +++
 rtl/vga_timing_receiver.sv | 165 ++++++++++++++++
 tb/tb_vga_timing_receiver.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_receiver_if.sv
// Video input stream and recovered pixel outputs of vga_timing_receiver.
// master: stream source and pixel consumer; slave: the receiver itself.
interface vga_timing_receiver_if;
    logic [7:0] video_red;
    logic [7:0] video_green;
    logic [7:0] video_blue;
    logic       video_horizontal_sync;
    logic       video_vertical_sync;
    logic       video_blank;
    logic [9:0] pixel_x_pos;
    logic [9:0] pixel_y_pos;
    logic [7:0] pixel_red;
    logic [7:0] pixel_green;
    logic [7:0] pixel_blue;
    logic       pixel_valid;
    logic       frame_start;
    logic       locked;
    logic [7:0] error_count;

    modport master (
        output video_red, video_green, video_blue,
        output video_horizontal_sync, video_vertical_sync, video_blank,
        input  pixel_x_pos, pixel_y_pos, pixel_red, pixel_green, pixel_blue,
        input  pixel_valid, frame_start, locked, error_count
    );

    modport slave (
        input  video_red, video_green, video_blue,
        input  video_horizontal_sync, video_vertical_sync, video_blank,
        output pixel_x_pos, pixel_y_pos, pixel_red, pixel_green, pixel_blue,
        output pixel_valid, frame_start, locked, error_count
    );
endinterface

// File: rtl/vga_timing_receiver.sv
// Recovers pixel coordinates from a VGA-style stream, qualifies the geometry and tracks lock.
// Two-register latency: s1 samples the inputs, outputs are registered from s1 plus counters.
module vga_timing_receiver #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input logic                  clock,
    input logic                  reset,
    vga_timing_receiver_if.slave vid_io
);

    typedef enum logic [1:0] {StIdle, StSearch, StLocked} state_e;

    logic [7:0] s1_red_q, s1_green_q, s1_blue_q;
    logic       s1_hs_q, s1_vs_q, s1_blank_q;
    logic       s2_vs_q, s2_blank_q;

    state_e     state_q, state_d;
    logic [3:0] good_q, good_d;
    logic [9:0] x_q, x_d, y_q, y_d, y_inc;
    logic       hs_seen_q, hs_seen_d, hs_seen_base;
    logic       frame_bad_q, frame_bad_d, frame_bad_now;
    logic [7:0] err_q, err_d;
    logic [8:0] err_sum;

    logic line_start, line_end, frame_sync;
    logic hs_err, len_err, line_err, frame_err;

    logic [9:0] px_q, py_q;
    logic [7:0] red_q, green_q, blue_q;
    logic       valid_q, valid_d, fs_q, fs_d, locked_q;

    always_comb begin
        line_start = s1_blank_q & ~s2_blank_q;
        line_end   = ~s1_blank_q & s2_blank_q;
        frame_sync = ~s1_vs_q & s2_vs_q;

        x_d = x_q;
        if (line_start) begin
            x_d = '0;
        end else if (s1_blank_q && (x_q != 10'h3ff)) begin
            x_d = x_q + 10'd1;
        end

        // Line end is counted before the frame check and before the clear.
        y_inc = (line_end && (y_q != 10'h3ff)) ? y_q + 10'd1 : y_q;
        y_d   = frame_sync ? '0 : y_inc;

        // hsync during active video is flagged only once per line.
        hs_seen_base = line_start ? 1'b0 : hs_seen_q;
        hs_err       = s1_blank_q & ~s1_hs_q & ~hs_seen_base;
        hs_seen_d    = hs_seen_base | (s1_blank_q & ~s1_hs_q);

        len_err   = line_end && ((32'(x_q) + 32'd1) != H_ACTIVE);
        line_err  = hs_err | len_err;
        frame_err = frame_sync && (state_q != StIdle) && (32'(y_inc) != V_ACTIVE);

        frame_bad_now = frame_bad_q | line_err | frame_err;
        frame_bad_d   = frame_sync ? 1'b0 : frame_bad_now;

        err_sum = {1'b0, err_q} + {8'd0, line_err} + {8'd0, frame_err};
        err_d   = err_sum[8] ? 8'hff : err_sum[7:0];

        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            StIdle: begin
                if (frame_sync) begin
                    state_d = StSearch;
                    good_d  = '0;
                end
            end
            StSearch: begin
                if (frame_sync) begin
                    if (frame_bad_now) begin
                        good_d = '0;
                    end else if ((32'(good_q) + 32'd1) >= LOCK_FRAMES) begin
                        state_d = StLocked;
                        good_d  = '0;
                    end else begin
                        good_d = good_q + 4'd1;
                    end
                end
            end
            StLocked: begin
                if (line_err || frame_err) begin
                    state_d = StSearch;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = StIdle;
                good_d  = '0;
            end
        endcase

        valid_d = (state_d == StLocked) & s1_blank_q &
                  (32'(x_d) < H_ACTIVE) & (32'(y_d) < V_ACTIVE);
        fs_d    = valid_d & (x_d == 10'd0) & (y_d == 10'd0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_red_q    <= '0;
            s1_green_q  <= '0;
            s1_blue_q   <= '0;
            s1_hs_q     <= 1'b1;
            s1_vs_q     <= 1'b1;
            s1_blank_q  <= 1'b0;
            s2_vs_q     <= 1'b1;
            s2_blank_q  <= 1'b0;
            state_q     <= StIdle;
            good_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            hs_seen_q   <= 1'b0;
            frame_bad_q <= 1'b0;
            err_q       <= '0;
            px_q        <= '0;
            py_q        <= '0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            valid_q     <= 1'b0;
            fs_q        <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            s1_red_q    <= vid_io.video_red;
            s1_green_q  <= vid_io.video_green;
            s1_blue_q   <= vid_io.video_blue;
            s1_hs_q     <= vid_io.video_horizontal_sync;
            s1_vs_q     <= vid_io.video_vertical_sync;
            s1_blank_q  <= vid_io.video_blank;
            s2_vs_q     <= s1_vs_q;
            s2_blank_q  <= s1_blank_q;
            state_q     <= state_d;
            good_q      <= good_d;
            x_q         <= x_d;
            y_q         <= y_d;
            hs_seen_q   <= hs_seen_d;
            frame_bad_q <= frame_bad_d;
            err_q       <= err_d;
            px_q        <= x_d;
            py_q        <= y_d;
            red_q       <= s1_red_q;
            green_q     <= s1_green_q;
            blue_q      <= s1_blue_q;
            valid_q     <= valid_d;
            fs_q        <= fs_d;
            locked_q    <= (state_d == StLocked);
        end
    end

    assign vid_io.pixel_x_pos = px_q;
    assign vid_io.pixel_y_pos = py_q;
    assign vid_io.pixel_red   = red_q;
    assign vid_io.pixel_green = green_q;
    assign vid_io.pixel_blue  = blue_q;
    assign vid_io.pixel_valid = valid_q;
    assign vid_io.frame_start = fs_q;
    assign vid_io.locked      = locked_q;
    assign vid_io.error_count = err_q;

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Directed bench for vga_timing_receiver with an 8x4 geometry and two-frame lock.
// A negedge monitor compares outputs with the stimulus delayed by two clocks.
module tb_vga_timing_receiver;
    localparam int unsigned HA = 8;
    localparam int unsigned VA = 4;
    localparam int unsigned LF = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    vga_timing_receiver_if vif ();

    vga_timing_receiver #(
        .H_ACTIVE   (HA),
        .V_ACTIVE   (VA),
        .LOCK_FRAMES(LF)
    ) dut (
        .clock (clock),
        .reset (reset),
        .vid_io(vif)
    );

    always #5 clock = ~clock;

    // Intended meaning of the cycle currently driven.
    logic       cur_act = 1'b0;
    logic [9:0] cur_x = '0;
    logic [9:0] cur_y = '0;

    logic [7:0] p1_r = '0, p1_g = '0, p1_b = '0, p2_r = '0, p2_g = '0, p2_b = '0;
    logic       p1_act = 1'b0, p2_act = 1'b0;
    logic [9:0] p1_x = '0, p1_y = '0, p2_x = '0, p2_y = '0;
    logic       mon_run = 1'b0;
    int valid_cnt = 0, fs_cnt = 0, fs_bad = 0, xy_bad = 0, rgb_bad = 0, max_x = 0, max_y = 0;

    initial begin
        forever begin
            @(negedge clock);
            if (mon_run) begin
                if ({vif.pixel_red, vif.pixel_green, vif.pixel_blue} !== {p2_r, p2_g, p2_b})
                    rgb_bad++;
                if (vif.pixel_valid === 1'b1) begin
                    valid_cnt++;
                    if (!p2_act || vif.pixel_x_pos !== p2_x || vif.pixel_y_pos !== p2_y)
                        xy_bad++;
                    if (int'(vif.pixel_x_pos) > max_x) max_x = int'(vif.pixel_x_pos);
                    if (int'(vif.pixel_y_pos) > max_y) max_y = int'(vif.pixel_y_pos);
                end
                if (vif.frame_start === 1'b1) begin
                    fs_cnt++;
                    if (!(p2_act && p2_x == 10'd0 && p2_y == 10'd0)) fs_bad++;
                end
            end
            p2_r = p1_r; p2_g = p1_g; p2_b = p1_b;
            p2_act = p1_act; p2_x = p1_x; p2_y = p1_y;
            p1_r = vif.video_red; p1_g = vif.video_green; p1_b = vif.video_blue;
            p1_act = cur_act; p1_x = cur_x; p1_y = cur_y;
        end
    end

    task automatic mon_clear();
        valid_cnt = 0; fs_cnt = 0; fs_bad = 0; xy_bad = 0; rgb_bad = 0; max_x = 0; max_y = 0;
        mon_run = 1'b1;
    endtask

    task automatic set_idle();
        vif.video_blank = 1'b0;
        vif.video_horizontal_sync = 1'b1;
        vif.video_vertical_sync = 1'b1;
        vif.video_red = '0;
        vif.video_green = '0;
        vif.video_blue = '0;
        cur_act = 1'b0;
    endtask

    task automatic step(input logic blank, input logic hs, input logic vs, input int x,
                        input int y);
        @(posedge clock);
        #2;
        vif.video_blank = blank;
        vif.video_horizontal_sync = hs;
        vif.video_vertical_sync = vs;
        vif.video_red = 8'($urandom);
        vif.video_green = 8'($urandom);
        vif.video_blue = 8'($urandom);
        cur_act = blank;
        cur_x = 10'(x);
        cur_y = 10'(y);
    endtask

    task automatic drive_line(input int npix, input int y, input bit tail);
        for (int i = 0; i < npix; i++) step(1'b1, 1'b1, 1'b1, i, y);
        if (tail) begin
            repeat (2) step(1'b0, 1'b1, 1'b1, 0, 0);
            repeat (2) step(1'b0, 1'b0, 1'b1, 0, 0);
            repeat (2) step(1'b0, 1'b1, 1'b1, 0, 0);
        end
    endtask

    task automatic drive_vsync(input bit early);
        if (!early) repeat (2) step(1'b0, 1'b1, 1'b1, 0, 0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 0, 0);
        repeat (3) step(1'b0, 1'b1, 1'b1, 0, 0);
    endtask

    task automatic drive_lines(input int n);
        for (int y = 0; y < n; y++) drive_line(HA, y, 1'b1);
    endtask

    task automatic test_reset();
        logic [54:0] outs;
        reset = 1'b0;
        set_idle();
        repeat (3) @(posedge clock);
        #2;
        outs = {vif.pixel_x_pos, vif.pixel_y_pos, vif.pixel_red, vif.pixel_green,
                vif.pixel_blue, vif.pixel_valid, vif.frame_start, vif.locked, vif.error_count};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_hold: outputs=%h expected 0", outs);
        end
        reset = 1'b1;
        repeat (2) step(1'b0, 1'b1, 1'b1, 0, 0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, i, 0);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        outs = {vif.pixel_x_pos, vif.pixel_y_pos, vif.pixel_red, vif.pixel_green,
                vif.pixel_blue, vif.pixel_valid, vif.frame_start, vif.locked, vif.error_count};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_async: outputs=%h expected 0", outs);
        end
        set_idle();
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        repeat (3) step(1'b0, 1'b1, 1'b1, 0, 0);
        checks++;
        if ({vif.locked, vif.error_count} !== 9'd0) begin
            errors++;
            $display("FAIL reset_release: locked/err=%h expected 0", {vif.locked, vif.error_count});
        end
    endtask

    task automatic test_lock();
        drive_vsync(1'b0);
        drive_lines(VA);
        drive_vsync(1'b0);
        checks++;
        if (vif.locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_early: locked=%b expected 0", vif.locked);
        end
        drive_lines(VA);
        drive_vsync(1'b0);
        checks++;
        if (vif.locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_third_vsync: locked=%b expected 1", vif.locked);
        end
        mon_clear();
        drive_lines(VA);
        step(1'b0, 1'b1, 1'b1, 0, 0);
        checks++;
        if (valid_cnt !== 32) begin
            errors++;
            $display("FAIL lock_valid_count: got %0d expected 32", valid_cnt);
        end
        checks++;
        if (xy_bad !== 0) begin
            errors++;
            $display("FAIL lock_xy: got %0d bad coordinates expected 0", xy_bad);
        end
        checks++;
        if (fs_cnt !== 1 || fs_bad !== 0) begin
            errors++;
            $display("FAIL lock_frame_start: got %0d pulses (%0d misplaced) expected 1 (0)",
                     fs_cnt, fs_bad);
        end
        checks++;
        if (max_x !== 7 || max_y !== 3) begin
            errors++;
            $display("FAIL lock_xy_max: got x=%0d y=%0d expected x=7 y=3", max_x, max_y);
        end
        checks++;
        if (rgb_bad !== 0) begin
            errors++;
            $display("FAIL lock_rgb_latency: got %0d mismatching cycles expected 0", rgb_bad);
        end
        checks++;
        if (vif.error_count !== 8'd0) begin
            errors++;
            $display("FAIL lock_err: got %0d expected 0", vif.error_count);
        end
    endtask

    task automatic test_long_line();
        drive_vsync(1'b0);
        mon_clear();
        drive_line(HA, 0, 1'b1);
        drive_line(HA + 1, 1, 1'b1);
        checks++;
        if (vif.locked !== 1'b0 || vif.error_count !== 8'd1) begin
            errors++;
            $display("FAIL long_line_drop: locked=%b err=%0d expected locked=0 err=1",
                     vif.locked, vif.error_count);
        end
        checks++;
        if (valid_cnt !== 16 || xy_bad !== 0) begin
            errors++;
            $display("FAIL long_line_valid: got %0d valid (%0d bad xy) expected 16 (0)",
                     valid_cnt, xy_bad);
        end
        mon_clear();
        drive_line(HA, 2, 1'b1);
        drive_line(HA, 3, 1'b1);
        drive_vsync(1'b0);
        drive_lines(VA);
        drive_vsync(1'b0);
        checks++;
        if (vif.locked !== 1'b0) begin
            errors++;
            $display("FAIL relock_early: locked=%b expected 0", vif.locked);
        end
        drive_lines(VA);
        drive_vsync(1'b0);
        checks++;
        if (vif.locked !== 1'b1 || vif.error_count !== 8'd1) begin
            errors++;
            $display("FAIL relock: locked=%b err=%0d expected locked=1 err=1",
                     vif.locked, vif.error_count);
        end
        checks++;
        if (valid_cnt !== 0 || rgb_bad !== 0) begin
            errors++;
            $display("FAIL relock_quiet: got %0d valid, %0d rgb bad expected 0, 0",
                     valid_cnt, rgb_bad);
        end
    endtask

    task automatic test_extra_line();
        mon_clear();
        drive_lines(VA + 1);
        checks++;
        if (vif.locked !== 1'b1) begin
            errors++;
            $display("FAIL extra_line_before_vsync: locked=%b expected 1", vif.locked);
        end
        checks++;
        if (valid_cnt !== 32 || xy_bad !== 0 || fs_cnt !== 1) begin
            errors++;
            $display("FAIL extra_line_valid: got %0d valid, %0d bad xy, %0d fs expected 32, 0, 1",
                     valid_cnt, xy_bad, fs_cnt);
        end
        drive_vsync(1'b0);
        checks++;
        if (vif.locked !== 1'b0 || vif.error_count !== 8'd2) begin
            errors++;
            $display("FAIL extra_line_frame_err: locked=%b err=%0d expected locked=0 err=2",
                     vif.locked, vif.error_count);
        end
    endtask

    // Last line's blank fall coincides with the vsync fall.
    task automatic test_coincident_edges();
        for (int f = 0; f < 2; f++) begin
            for (int y = 0; y < 3; y++) drive_line(HA, y, 1'b1);
            drive_line(HA, 3, 1'b0);
            drive_vsync(1'b1);
            checks++;
            if (vif.locked !== 1'(f) || vif.error_count !== 8'd2) begin
                errors++;
                $display("FAIL coincident_%0d: locked=%b err=%0d expected locked=%0d err=2",
                         f, vif.locked, vif.error_count, f);
            end
        end
    endtask

    task automatic test_saturation();
        mon_clear();
        for (int i = 0; i < 100; i++) begin
            drive_vsync(1'b0);
            drive_line(HA, 0, 1'b1);
        end
        checks++;
        if (vif.error_count !== 8'd102 || vif.locked !== 1'b0) begin
            errors++;
            $display("FAIL sat_mid: err=%0d locked=%b expected err=102 locked=0",
                     vif.error_count, vif.locked);
        end
        for (int i = 0; i < 200; i++) begin
            drive_vsync(1'b0);
            drive_line(HA, 0, 1'b1);
        end
        checks++;
        if (vif.error_count !== 8'd255) begin
            errors++;
            $display("FAIL sat_full: err=%0d expected 255", vif.error_count);
        end
        drive_vsync(1'b0);
        drive_line(HA, 0, 1'b1);
        checks++;
        if (vif.error_count !== 8'd255) begin
            errors++;
            $display("FAIL sat_no_wrap: err=%0d expected 255", vif.error_count);
        end
        checks++;
        if (valid_cnt !== 0 || rgb_bad !== 0) begin
            errors++;
            $display("FAIL sat_quiet: got %0d valid, %0d rgb bad expected 0, 0",
                     valid_cnt, rgb_bad);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_long_line();
        test_extra_line();
        test_coincident_edges();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
